// File: rtl/param_inst_decoder_pkg.sv
// Shared opcode table, FSM encodings and operand-count lookup
// for the parametrised instruction decoder.
package param_inst_decoder_pkg;

    typedef logic [15:0] opc_t;

    localparam opc_t OP_NOP    = 16'h0000;
    localparam opc_t OP_LOAD   = 16'h0001;
    localparam opc_t OP_MOV_RR = 16'h0002;
    localparam opc_t OP_MOV_RA = 16'h0003;
    localparam opc_t OP_ADD    = 16'h0004;
    localparam opc_t OP_JMP    = 16'h0005;
    localparam opc_t OP_IRET   = 16'h0006;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_ARGS    = 3'd1,
        S_ISSUE   = 3'd2,
        S_WB      = 3'd3,
        S_ILLEGAL = 3'd4
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [1:0] count;
    } opc_info_t;

    function automatic opc_info_t opc_info(input opc_t opc);
        opc_info_t r;
        r.legal = 1'b1;
        r.count = 2'd0;
        case (opc)
            OP_NOP, OP_IRET: r.count = 2'd0;
            OP_JMP:          r.count = 2'd1;
            OP_LOAD, OP_MOV_RR,
            OP_MOV_RA, OP_ADD: r.count = 2'd2;
            default:         r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/param_inst_decoder_if.sv
// Bus word handshake between the bus interface and the decoder.
interface param_inst_decoder_if #(
    parameter int DATA_W = 16
);
    logic              i_word_valid;
    logic [DATA_W-1:0] i_word;
    logic              o_word_ready;

    modport master (
        output i_word_valid,
        output i_word,
        input  o_word_ready
    );

    modport slave (
        input  i_word_valid,
        input  i_word,
        output o_word_ready
    );
endinterface

// File: rtl/param_inst_decoder_ctx.sv
// Shadow copy of the sequencing context taken on interrupt entry
// and handed back on IRET.
module param_inst_decoder_ctx
    import param_inst_decoder_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int OPC_W    = 8,
    parameter int MAX_ARGS = 3,
    parameter int ARGCNT_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       save,
    input  logic                       restore,
    input  state_t                     state_in,
    input  logic [ARGCNT_W-1:0]        idx_in,
    input  logic [OPC_W-1:0]           opc_in,
    input  logic [MAX_ARGS*DATA_W-1:0] args_in,
    output state_t                     state_out,
    output logic [ARGCNT_W-1:0]        idx_out,
    output logic [OPC_W-1:0]           opc_out,
    output logic [MAX_ARGS*DATA_W-1:0] args_out,
    output logic                       valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_out <= S_FETCH;
            idx_out   <= '0;
            opc_out   <= '0;
            args_out  <= '0;
            valid     <= 1'b0;
        end else if (save) begin
            state_out <= state_in;
            idx_out   <= idx_in;
            opc_out   <= opc_in;
            args_out  <= args_in;
            valid     <= (state_in == S_ARGS);
        end else if (restore) begin
            valid     <= 1'b0;
        end
    end

endmodule

// File: rtl/param_inst_decoder.sv
// Fetch/decode sequencer: gathers opcode plus operands from the bus
// and issues a one-cycle decoded bundle; supports one interrupt level.
module param_inst_decoder
    import param_inst_decoder_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int OPC_W    = 8,
    parameter int MAX_ARGS = 3,
    parameter int ARGCNT_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_interrupt,
    input  logic                       i_stall,
    param_inst_decoder_if.slave        bus,
    output logic                       o_fetch,
    output logic                       o_inst_valid,
    output logic [OPC_W-1:0]           o_opcode,
    output logic [MAX_ARGS*DATA_W-1:0] o_args,
    output logic [ARGCNT_W-1:0]        o_arg_count,
    output logic                       o_pc_load,
    output logic                       o_wb,
    output logic                       o_illegal,
    output logic                       o_int_active
);

    localparam int AW = MAX_ARGS * DATA_W;

    function automatic opc_t to_opc(input logic [OPC_W-1:0] o);
        return opc_t'(o);
    endfunction

    state_t              state_q, state_d;
    logic [ARGCNT_W-1:0] idx_q, idx_d;
    logic [OPC_W-1:0]    opc_q, opc_d;
    logic [AW-1:0]       args_q, args_d;
    logic                int_q, int_d;
    logic                pend_q, pend_d;

    state_t              ctx_state;
    logic [ARGCNT_W-1:0] ctx_idx;
    logic [OPC_W-1:0]    ctx_opc;
    logic [AW-1:0]       ctx_args;
    logic                ctx_valid;

    logic                collecting, take_int, ready, accept;
    logic                save, restore;
    logic [OPC_W-1:0]    word_opc;
    opc_info_t           word_info, run_info, issue_info;
    logic [ARGCNT_W-1:0] run_cnt;

    assign collecting = (state_q == S_FETCH) || (state_q == S_ARGS);
    assign take_int   = (i_interrupt || pend_q) && !int_q && collecting;
    assign ready      = collecting && !i_stall && !take_int && !rst;
    assign accept     = bus.i_word_valid && ready;
    assign word_opc   = bus.i_word[OPC_W-1:0];
    assign word_info  = opc_info(to_opc(word_opc));
    assign run_info   = opc_info(to_opc(opc_q));
    assign run_cnt    = ARGCNT_W'(run_info.count);
    assign issue_info = opc_info(to_opc(opc_d));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        opc_d   = opc_q;
        args_d  = args_q;
        int_d   = int_q;
        pend_d  = pend_q;
        save    = 1'b0;
        restore = 1'b0;
        // requests during single-cycle states wait for the next fetch
        if (i_interrupt && !int_q && !collecting)
            pend_d = 1'b1;
        if (take_int) begin
            save    = 1'b1;
            state_d = S_FETCH;
            int_d   = 1'b1;
            pend_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_FETCH: if (accept) begin
                    opc_d  = word_opc;
                    args_d = '0;
                    idx_d  = '0;
                    if (!word_info.legal ||
                        (to_opc(word_opc) == OP_IRET && !int_q))
                        state_d = S_ILLEGAL;
                    else if (word_info.count == 2'd0)
                        state_d = S_ISSUE;
                    else
                        state_d = S_ARGS;
                end
                S_ARGS: if (accept) begin
                    for (int k = 0; k < MAX_ARGS; k++)
                        if (idx_q == ARGCNT_W'(k))
                            args_d[k*DATA_W +: DATA_W] = bus.i_word;
                    idx_d = idx_q + ARGCNT_W'(1);
                    if (idx_q == run_cnt - ARGCNT_W'(1))
                        state_d = S_ISSUE;
                end
                S_ISSUE: begin
                    unique case (1'b1)
                        to_opc(opc_q) == OP_IRET: begin
                            restore = 1'b1;
                            int_d   = 1'b0;
                            if (ctx_valid) begin
                                state_d = ctx_state;
                                idx_d   = ctx_idx;
                                opc_d   = ctx_opc;
                                args_d  = ctx_args;
                            end else begin
                                state_d = S_FETCH;
                            end
                        end
                        to_opc(opc_q) == OP_MOV_RA: state_d = S_WB;
                        default:                    state_d = S_FETCH;
                    endcase
                end
                S_WB:      state_d = S_FETCH;
                S_ILLEGAL: state_d = S_FETCH;
                default:   state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            idx_q       <= '0;
            opc_q       <= '0;
            args_q      <= '0;
            int_q       <= 1'b0;
            pend_q      <= 1'b0;
            o_opcode    <= '0;
            o_args      <= '0;
            o_arg_count <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opc_q   <= opc_d;
            args_q  <= args_d;
            int_q   <= int_d;
            pend_q  <= pend_d;
            if (state_d == S_ISSUE) begin
                o_opcode    <= opc_d;
                o_args      <= args_d;
                o_arg_count <= ARGCNT_W'(issue_info.count);
            end
        end
    end

    param_inst_decoder_ctx #(
        .DATA_W   (DATA_W),
        .OPC_W    (OPC_W),
        .MAX_ARGS (MAX_ARGS),
        .ARGCNT_W (ARGCNT_W)
    ) u_ctx (
        .clk       (clk),
        .rst       (rst),
        .save      (save),
        .restore   (restore),
        .state_in  (state_q),
        .idx_in    (idx_q),
        .opc_in    (opc_q),
        .args_in   (args_q),
        .state_out (ctx_state),
        .idx_out   (ctx_idx),
        .opc_out   (ctx_opc),
        .args_out  (ctx_args),
        .valid     (ctx_valid)
    );

    assign bus.o_word_ready = ready;
    assign o_fetch          = ready;
    assign o_inst_valid     = (state_q == S_ISSUE);
    assign o_pc_load        = (state_q == S_ISSUE) &&
                              (to_opc(opc_q) == OP_JMP);
    assign o_wb             = (state_q == S_WB);
    assign o_illegal        = (state_q == S_ILLEGAL);
    assign o_int_active     = int_q;

endmodule

// File: tb/tb_param_inst_decoder.sv
// Self-checking bench: vector table plus interrupt/reset sequences,
// issue events checked against a queue of expected bundles.
module tb_param_inst_decoder;

    logic        clk;
    logic        rst;
    logic        intr;
    logic        stall;
    logic        o_fetch, o_inst_valid, o_pc_load, o_wb;
    logic        o_illegal, o_int_active;
    logic [7:0]  o_opcode;
    logic [47:0] o_args;
    logic [1:0]  o_arg_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    param_inst_decoder_if #(.DATA_W(16)) bus ();

    param_inst_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .i_interrupt  (intr),
        .i_stall      (stall),
        .bus          (bus),
        .o_fetch      (o_fetch),
        .o_inst_valid (o_inst_valid),
        .o_opcode     (o_opcode),
        .o_args       (o_args),
        .o_arg_count  (o_arg_count),
        .o_pc_load    (o_pc_load),
        .o_wb         (o_wb),
        .o_illegal    (o_illegal),
        .o_int_active (o_int_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        ill;
        logic [7:0]  opc;
        logic [1:0]  cnt;
        logic [47:0] args;
        logic        pcl;
        logic        wb;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [3:0][15:0] words;
        int               nw;
        int               sat;
        int               slen;
        logic             ill;
        logic [1:0]       cnt;
        logic [47:0]      args;
        logic             pcl;
        logic             wb;
    } vec_t;

    exp_t q[$];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic ill, input logic [7:0] opc,
                        input logic [1:0] cnt, input logic [47:0] args,
                        input logic pcl, input logic wb, input int c);
        exp_t e;
        e.ill = ill; e.opc = opc; e.cnt = cnt; e.args = args;
        e.pcl = pcl; e.wb = wb; e.cyc = c;
        q.push_back(e);
    endtask

    // monitor: pops one expected bundle per issue/illegal pulse
    logic wb_exp = 1'b0;
    always @(negedge clk) begin : mon
        logic wb_now;
        exp_t e;
        wb_now = wb_exp;
        wb_exp = 1'b0;
        if (wb_now || o_wb) check("wb_strobe", 64'(o_wb), 64'(wb_now));
        if (o_inst_valid || o_illegal) begin
            if (q.size() == 0) begin
                check("unexpected_event",
                      64'({o_inst_valid, o_illegal}), 64'd0);
            end else begin
                e = q.pop_front();
                check("ev_illegal", 64'(o_illegal), 64'(e.ill));
                check("ev_valid", 64'(o_inst_valid), 64'(!e.ill));
                check("ev_cycle", 64'(cyc), 64'(e.cyc));
                if (!e.ill) begin
                    check("opcode", 64'(o_opcode), 64'(e.opc));
                    check("arg_count", 64'(o_arg_count), 64'(e.cnt));
                    check("args", 64'(o_args), 64'(e.args));
                    check("pc_load", 64'(o_pc_load), 64'(e.pcl));
                    wb_exp = e.wb;
                end
            end
        end else if (o_pc_load) begin
            check("stray_pc_load", 64'(o_pc_load), 64'd0);
        end
    end

    // entered at posedge+1; returns at posedge+1 of the next period
    task automatic send(input logic [15:0] w, output int acc);
        int n;
        n = 0;
        bus.i_word_valid = 1'b1;
        bus.i_word = w;
        #1;
        while (!bus.o_word_ready && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        if (!bus.o_word_ready)
            check("send_timeout", 64'(bus.o_word_ready), 64'd1);
        acc = cyc;
        @(posedge clk); #1;
        bus.i_word_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ready"}, 64'(bus.o_word_ready), 64'd0);
        check({tag, "_fetch"}, 64'(o_fetch), 64'd0);
        check({tag, "_valid"}, 64'(o_inst_valid), 64'd0);
        check({tag, "_opcode"}, 64'(o_opcode), 64'd0);
        check({tag, "_args"}, 64'(o_args), 64'd0);
        check({tag, "_count"}, 64'(o_arg_count), 64'd0);
        check({tag, "_pcload"}, 64'(o_pc_load), 64'd0);
        check({tag, "_wb"}, 64'(o_wb), 64'd0);
        check({tag, "_illegal"}, 64'(o_illegal), 64'd0);
        check({tag, "_intact"}, 64'(o_int_active), 64'd0);
    endtask

    vec_t tbl[9];

    initial begin : main
        int   a, acc0;
        vec_t v;

        tbl[0] = '{words: 64'h0000_0002_0001_0004, nw: 3, sat: 0, slen: 0,
                   ill: 0, cnt: 2, args: 48'h0000_0002_0001, pcl: 0, wb: 0};
        tbl[1] = '{words: 64'h0000_0000_1234_0005, nw: 2, sat: 0, slen: 0,
                   ill: 0, cnt: 1, args: 48'h0000_0000_1234, pcl: 1, wb: 0};
        tbl[2] = '{words: 64'h0000_00A0_0002_0003, nw: 3, sat: 0, slen: 0,
                   ill: 0, cnt: 2, args: 48'h0000_00A0_0002, pcl: 0, wb: 1};
        tbl[3] = '{words: 64'h0000_0000_0000_0000, nw: 1, sat: 0, slen: 0,
                   ill: 0, cnt: 0, args: 48'h0, pcl: 0, wb: 0};
        tbl[4] = '{words: 64'h0000_5555_AAAA_0001, nw: 3, sat: 2, slen: 3,
                   ill: 0, cnt: 2, args: 48'h0000_5555_AAAA, pcl: 0, wb: 0};
        tbl[5] = '{words: 64'h0000_0008_0007_0102, nw: 3, sat: 0, slen: 0,
                   ill: 0, cnt: 2, args: 48'h0000_0008_0007, pcl: 0, wb: 0};
        tbl[6] = '{words: 64'h0000_0000_0000_00FF, nw: 1, sat: 0, slen: 0,
                   ill: 1, cnt: 0, args: 48'h0, pcl: 0, wb: 0};
        tbl[7] = '{words: 64'h0000_0000_0000_0006, nw: 1, sat: 0, slen: 0,
                   ill: 1, cnt: 0, args: 48'h0, pcl: 0, wb: 0};
        tbl[8] = '{words: 64'h0000_0000_0000_0007, nw: 1, sat: 0, slen: 0,
                   ill: 1, cnt: 0, args: 48'h0, pcl: 0, wb: 0};

        rst = 1'b1; intr = 1'b0; stall = 1'b0;
        bus.i_word_valid = 1'b0; bus.i_word = '0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            v = tbl[i];
            acc0 = 0;
            for (int w = 0; w < v.nw; w++) begin
                if (w == v.sat && v.slen > 0) begin
                    bus.i_word_valid = 1'b1;
                    bus.i_word = v.words[w];
                    stall = 1'b1;
                    repeat (v.slen) begin
                        #1;
                        check("stall_ready", 64'(bus.o_word_ready), 64'd0);
                        @(posedge clk); #1;
                    end
                    stall = 1'b0;
                end
                send(v.words[w], a);
                if (w == 0) acc0 = a;
            end
            push(v.ill, v.words[0][7:0], v.cnt, v.args, v.pcl, v.wb,
                 acc0 + v.nw + v.slen);
            @(posedge clk); #2;
            check("ready_after", 64'(bus.o_word_ready), 64'(!v.wb));
            if (v.wb) begin
                @(posedge clk); #2;
                check("ready_after_wb", 64'(bus.o_word_ready), 64'd1);
            end
            @(posedge clk); #1;
        end

        // interrupt arriving during an ISSUE cycle is held and taken next
        send(16'h0000, a);
        push(0, 8'h00, 2'd0, 48'h0, 0, 0, a + 1);
        intr = 1'b1;
        @(posedge clk); #1;
        intr = 1'b0;
        #1;
        check("pend_ready", 64'(bus.o_word_ready), 64'd0);
        @(posedge clk); #2;
        check("pend_int_active", 64'(o_int_active), 64'd1);
        @(posedge clk); #1;
        send(16'h0006, a);
        push(0, 8'h06, 2'd0, 48'h0, 0, 0, a + 1);
        @(posedge clk); #2;
        check("pend_iret_clear", 64'(o_int_active), 64'd0);
        check("pend_iret_ready", 64'(bus.o_word_ready), 64'd1);
        @(posedge clk); #1;

        // interrupt mid-LOAD; handler runs NOP and IRET; LOAD resumes
        send(16'h0001, a);
        send(16'h1111, a);
        intr = 1'b1;
        bus.i_word_valid = 1'b1;
        bus.i_word = 16'h2222;
        #1;
        check("int_take_ready", 64'(bus.o_word_ready), 64'd0);
        @(posedge clk); #1;
        intr = 1'b0;
        bus.i_word_valid = 1'b0;
        #1;
        check("int_active_set", 64'(o_int_active), 64'd1);
        @(posedge clk); #1;
        send(16'h0000, a);
        push(0, 8'h00, 2'd0, 48'h0, 0, 0, a + 1);
        send(16'h0006, a);
        push(0, 8'h06, 2'd0, 48'h0, 0, 0, a + 1);
        @(posedge clk); #2;
        check("iret_int_clear", 64'(o_int_active), 64'd0);
        check("iret_resume_ready", 64'(bus.o_word_ready), 64'd1);
        @(posedge clk); #1;
        send(16'h0007, a);
        push(0, 8'h01, 2'd2, 48'h0000_0007_1111, 0, 0, a + 1);
        idle(2);

        // reset mid-ARGS while an interrupt is active
        send(16'h0004, a);
        send(16'h0055, a);
        intr = 1'b1;
        @(posedge clk); #1;
        intr = 1'b0;
        #1;
        check("pre_rst_int", 64'(o_int_active), 64'd1);
        rst = 1'b1;
        @(posedge clk); #2;
        check_reset_outs("midrst");
        rst = 1'b0;
        @(posedge clk); #1;
        send(16'h0006, a);
        push(1, 8'h00, 2'd0, 48'h0, 0, 0, a + 1);
        idle(2);
        send(16'h0004, a);
        acc0 = a;
        send(16'h0009, a);
        send(16'h000A, a);
        push(0, 8'h04, 2'd2, 48'h0000_000A_0009, 0, 0, acc0 + 3);
        idle(3);

        check("queue_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
